// File: rtl/secure_voting_machine.sv
// Password-gated three-candidate ballot counter with saturating 8-bit tallies,
// wrong-password lockout and a registered winner published when the election closes.
module secure_voting_machine #(
  parameter logic [3:0] ADMIN_KEY = 4'b1010,
  parameter int         MAX_FAILS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] admin_password,
  input  logic       enable_admin,
  input  logic       result_mode,
  input  logic       vote_a,
  input  logic       vote_b,
  input  logic       vote_c,
  output logic [7:0] count_a,
  output logic [7:0] count_b,
  output logic [7:0] count_c,
  output logic [1:0] winner,
  output logic       voting_enabled,
  output logic       busy
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    LOCKOUT = 3'd1,
    READY   = 3'd2,
    HOLD    = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [FW-1:0]   r_fail_cnt;
  logic [FW-1:0]   w_fail_next;
  logic [2:0]      r_prev_vote;
  logic            r_prev_admin;
  logic [7:0]      r_count [3];
  logic [7:0]      w_count_next [3];
  logic [1:0]      r_winner;
  logic [1:0]      w_winner_next;
  logic            r_voting_enabled;
  logic            r_busy;
  logic            w_ve_next;
  logic            w_busy_next;
  logic [2:0]      w_vote;
  logic [2:0]      w_vote_rise;
  logic            w_admin_rise;
  logic [1:0]      w_winner_calc;

  assign w_vote       = {vote_c, vote_b, vote_a};
  assign w_vote_rise  = w_vote & ~r_prev_vote;
  assign w_admin_rise = enable_admin & ~r_prev_admin;

  // A strictly largest tally wins; any shared maximum (including all zero) is a tie.
  always_comb begin
    w_winner_calc = 2'b00;
    if (r_count[0] > r_count[1] && r_count[0] > r_count[2])
      w_winner_calc = 2'b01;
    else if (r_count[1] > r_count[0] && r_count[1] > r_count[2])
      w_winner_calc = 2'b10;
    else if (r_count[2] > r_count[0] && r_count[2] > r_count[1])
      w_winner_calc = 2'b11;
  end

  always_comb begin
    w_state_next  = r_state;
    w_fail_next   = r_fail_cnt;
    w_winner_next = r_winner;
    for (int i = 0; i < 3; i++)
      w_count_next[i] = r_count[i];

    case (r_state)
      LOCKED: begin
        if (w_admin_rise) begin
          if (admin_password == ADMIN_KEY) begin
            w_state_next = READY;
            w_fail_next  = '0;
          end else begin
            w_fail_next = r_fail_cnt + FW'(1);
            if (w_fail_next == FAIL_LIMIT)
              w_state_next = LOCKOUT;
          end
        end
      end
      READY: begin
        // Closing the election wins over a vote edge on the same cycle.
        if (result_mode) begin
          w_state_next  = RESULT;
          w_winner_next = w_winner_calc;
        end else if (|w_vote_rise) begin
          w_state_next = HOLD;
          if ($onehot(w_vote_rise)) begin
            for (int i = 0; i < 3; i++)
              if (w_vote_rise[i] && r_count[i] != 8'hFF)
                w_count_next[i] = r_count[i] + 8'd1;
          end
        end
      end
      HOLD: begin
        if (result_mode) begin
          w_state_next  = RESULT;
          w_winner_next = w_winner_calc;
        end else if (w_vote == 3'b000) begin
          w_state_next = READY;
        end
      end
      default: begin
      end
    endcase

    w_ve_next   = (w_state_next == READY) || (w_state_next == HOLD);
    w_busy_next = (w_state_next == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= LOCKED;
      r_fail_cnt       <= '0;
      r_prev_vote      <= 3'b000;
      r_prev_admin     <= 1'b0;
      r_winner         <= 2'b00;
      r_voting_enabled <= 1'b0;
      r_busy           <= 1'b0;
      for (int i = 0; i < 3; i++)
        r_count[i] <= 8'd0;
    end else begin
      r_state          <= w_state_next;
      r_fail_cnt       <= w_fail_next;
      r_prev_vote      <= w_vote;
      r_prev_admin     <= enable_admin;
      r_winner         <= w_winner_next;
      r_voting_enabled <= w_ve_next;
      r_busy           <= w_busy_next;
      for (int i = 0; i < 3; i++)
        r_count[i] <= w_count_next[i];
    end
  end

  assign count_a        = r_count[0];
  assign count_b        = r_count[1];
  assign count_c        = r_count[2];
  assign winner         = r_winner;
  assign voting_enabled = r_voting_enabled;
  assign busy           = r_busy;

endmodule

// File: tb/tb_secure_voting_machine.sv
// Directed bench: each step drives inputs, queues the expected outputs, and
// checks them against the DUT one time unit after the next rising edge.
module tb_secure_voting_machine;

  logic       clk;
  logic       rst_n;
  logic [3:0] pw;
  logic       adm;
  logic       rm;
  logic       va;
  logic       vb;
  logic       vc;
  logic [7:0] count_a;
  logic [7:0] count_b;
  logic [7:0] count_c;
  logic [1:0] winner;
  logic       voting_enabled;
  logic       busy;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [1:0] w;
    logic       ve;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  logic [7:0] e_a;
  logic [7:0] e_b;
  logic [7:0] e_c;
  logic [1:0] e_w;
  logic       e_ve;
  logic       e_busy;

  int n_assert = 0;
  int n_fail   = 0;

  secure_voting_machine dut (
    .clk            (clk),
    .reset          (rst_n),
    .admin_password (pw),
    .enable_admin   (adm),
    .result_mode    (rm),
    .vote_a         (va),
    .vote_b         (vb),
    .vote_c         (vc),
    .count_a        (count_a),
    .count_b        (count_b),
    .count_c        (count_c),
    .winner         (winner),
    .voting_enabled (voting_enabled),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e = '{a: e_a, b: e_b, c: e_c, w: e_w, ve: e_ve, busy: e_busy};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "count_a", count_a, e.a);
    chk(t, "count_b", count_b, e.b);
    chk(t, "count_c", count_c, e.c);
    chk(t, "winner", {6'd0, winner}, {6'd0, e.w});
    chk(t, "voting_enabled", {7'd0, voting_enabled}, {7'd0, e.ve});
    chk(t, "busy", {7'd0, busy}, {7'd0, e.busy});
    $display("step %-12s a=%0d b=%0d c=%0d w=%0d ve=%0d busy=%0d", t,
             count_a, count_b, count_c, winner, voting_enabled, busy);
  endtask

  // Inputs are already set (we sit at a falling edge); clock once and compare.
  task automatic step(input string tag);
    push_exp(tag);
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
  endtask

  task automatic expect_zero();
    e_a = 0; e_b = 0; e_c = 0; e_w = 2'b00; e_ve = 1'b0; e_busy = 1'b0;
  endtask

  task automatic idle_inputs();
    adm = 1'b0; rm = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0;
  endtask

  // Reset is dropped between clock edges and checked before any edge arrives.
  task automatic async_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    expect_zero();
    push_exp(tag);
    pop_check();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic unlock(input string tag);
    pw = 4'b1010; adm = 1'b1; e_ve = 1'b1;
    step(tag);
    adm = 1'b0;
    step({tag, "_rel"});
  endtask

  task automatic pulse_vote(input string tag, input int which);
    va = (which == 0); vb = (which == 1); vc = (which == 2);
    e_busy = 1'b1;
    step(tag);
    va = 1'b0; vb = 1'b0; vc = 1'b0; e_busy = 1'b0;
    step({tag, "_rel"});
    step({tag, "_idle"});
  endtask

  initial begin
    rst_n = 1'b0;
    pw = 4'b0000;
    idle_inputs();
    expect_zero();
    #12;
    push_exp("reset");
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset");

    // Basic unlock, one vote each, tie on close
    unlock("unlock1");
    e_a = 1; pulse_vote("vote_a", 0);
    e_b = 1; pulse_vote("vote_b", 1);
    e_c = 1; pulse_vote("vote_c", 2);
    rm = 1'b1; e_ve = 1'b0; e_w = 2'b00;
    step("close_tie");
    rm = 1'b0;
    step("result_hold");
    async_reset("rst_result1");

    // Held button counts once; simultaneous rise rejected; close wins over vote
    unlock("unlock2");
    va = 1'b1; e_a = 1; e_busy = 1'b1;
    for (int i = 0; i < 5; i++) step("hold_a");
    va = 1'b0; e_busy = 1'b0;
    step("release_a");
    e_a = 2; pulse_vote("vote_a2", 0);
    va = 1'b1; vb = 1'b1; e_busy = 1'b1;
    step("double_ab");
    va = 1'b0; vb = 1'b0; e_busy = 1'b0;
    step("double_rel");
    rm = 1'b1; vc = 1'b1; e_ve = 1'b0; e_w = 2'b01;
    step("close_vs_c");
    rm = 1'b0; vc = 1'b0;
    step("result_a");
    async_reset("rst_result2");

    // Three wrong passwords lock the machine permanently
    for (int i = 0; i < 3; i++) begin
      pw = 4'b0101; adm = 1'b1;
      step("bad_pw");
      adm = 1'b0;
      step("bad_pw_rel");
    end
    pw = 4'b1010; adm = 1'b1;
    step("lockout_key");
    adm = 1'b0;
    step("lockout_rel");
    va = 1'b1; step("lockout_va");
    va = 1'b0; vb = 1'b1; step("lockout_vb");
    vb = 1'b0; rm = 1'b1; step("lockout_rm");
    rm = 1'b0; step("lockout_idle");
    async_reset("rst_lockout");

    // Votes and result_mode before unlock have no effect
    vc = 1'b1; step("pre_vote_c");
    vc = 1'b0; step("pre_vote_rel");
    rm = 1'b1; step("pre_result");
    rm = 1'b0; step("pre_result_rel");
    unlock("unlock4");

    // Saturation at 255, then close from HOLD
    for (int i = 1; i <= 255; i++) begin
      vb = 1'b1; e_b = 8'(i); e_busy = 1'b1;
      step("vote_b_n");
      vb = 1'b0; e_busy = 1'b0;
      step("vote_b_rel");
    end
    vb = 1'b1; e_busy = 1'b1;
    step("vote_b_sat");
    rm = 1'b1; e_busy = 1'b0; e_ve = 1'b0; e_w = 2'b10;
    step("close_hold");
    rm = 1'b0; vb = 1'b0;
    step("result_b");
    async_reset("rst_result3");

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/secure_voting_machine.md
# secure_voting_machine

Password-gated three-candidate electronic ballot counter. An administrator unlocks voting with a 4-bit password. Each voter pulse for candidate A, B or C adds one to that candidate's 8-bit tally. Asserting result mode closes the election and publishes the winner. The block is a standalone leaf under the system top and talks to switch/button-level inputs and display-level outputs.

## Interface
- ADMIN_KEY, 4'b1010, password that unlocks voting
- MAX_FAILS, 3, consecutive wrong-password attempts before permanent lockout
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- admin_password  in  4  password presented with enable_admin
- enable_admin  in  1  admin unlock request; rising-edge detected
- result_mode  in  1  level; 1 closes voting and publishes the winner
- vote_a / vote_b / vote_c  in  1 each  voter buttons; rising-edge detected
- count_a / count_b / count_c  out  8 each  candidate tallies
- winner  out  2  00 = none/tie, 01 = A, 10 = B, 11 = C
- voting_enabled  out  1  high while ballots are accepted
- busy  out  1  high while a registered vote awaits button release

## Operation
- One clock. Reset is asynchronous and active-low.
- Reset (reset low): all counts = 0, winner = 00, voting_enabled = 0, busy = 0, fail counter = 0, state = LOCKED. The previous-sample registers for vote and enable_admin inputs are cleared.
- Edge detection: an input "rises" on a cycle where it is sampled 1 and its previous sample was 0.
- States:
  - LOCKED
    - enable_admin rises with admin_password == ADMIN_KEY → READY; fail counter cleared.
    - enable_admin rises with a wrong password → fail counter +1. Reaching MAX_FAILS → LOCKOUT.
    - Vote inputs are ignored.
  - LOCKOUT: terminal until reset. All inputs are ignored and voting_enabled = 0.
  - READY: voting_enabled = 1.
    - Exactly one vote input rises → that count +1 (saturates at 255) → HOLD.
    - Two or more vote inputs rise on the same cycle → no count changes → HOLD. The ballot is rejected.
    - result_mode = 1 → RESULT. This takes priority over any vote edge on the same cycle; that vote is discarded.
  - HOLD: busy = 1, voting_enabled = 1, and no vote is counted.
    - All vote inputs sampled 0 → READY.
    - result_mode = 1 → RESULT.
  - RESULT: terminal until reset. voting_enabled = 0, busy = 0, and counts are frozen.
    - winner = the candidate with the strictly largest count.
    - If the maximum is shared by two or more candidates, or all counts are 0, winner = 00.
- result_mode asserted in LOCKED or LOCKOUT has no effect. An election cannot close before it has opened.
- Outside RESULT, winner = 00.
- enable_admin is ignored outside LOCKED.
- Counts are 8-bit unsigned, never wrap, and hold at 255.

## Timing
- All outputs are registered.
- Unlock: voting_enabled is high after the clock edge at which the enable_admin rise with the correct password is sampled (latency 1 edge).
- Vote: the count increments and busy asserts at the same edge that samples the rising vote. Both are visible from that edge onward.
- busy deasserts at the edge that samples all vote inputs low. A vote held high for N cycles counts once.
- A vote that rises on the edge where HOLD returns to READY is not counted. The button must be released and pressed again.
- Result: at the edge sampling result_mode = 1 in READY/HOLD, the state becomes RESULT, voting_enabled and busy fall, and winner becomes valid at that same edge.
- Reset mid-operation (any state) clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset low, then high. Pulse enable_admin for 1 cycle with password 1010 → voting_enabled = 1 one edge later. Counts stay 0 and winner stays 00.
- After unlock, one-cycle pulses on vote_a, then vote_b, then vote_c, each separated by idle cycles → count_a = count_b = count_c = 1, busy high for one cycle per vote. Then result_mode = 1 → voting_enabled = 0, winner = 00 (tie).
- Hold vote_a high for 5 cycles, release, and pulse it again → count_a = 2. busy stays high while held. Then vote_a and vote_b rise on the same cycle → count_a/count_b unchanged. Then result_mode = 1 → winner = 01.
- Present password 0101 three times with enable_admin pulses → LOCKOUT. A later correct 1010 leaves voting_enabled = 0. Vote pulses leave all counts 0.
- Before unlock, pulse vote_c and set result_mode = 1 → count_c = 0 and winner = 00. Unlock still succeeds after result_mode returns to 0.
- With 255 votes for B then one more → count_b = 255. result_mode = 1 → winner = 10. Assert reset in RESULT → all outputs 0 immediately.
